bch_par_enc: RTL and testbench
==============================

BCH_PAR_ENC -- requirements
Module: bch_par_enc

Interface
REQ-001 SHALL have parameter K, default 128: data bits per codeword.
REQ-002 SHALL have parameter P, default 16: BCH parity bits; degree of the generator polynomial.
REQ-003 SHALL have parameter CHUNK, default 32: data bits absorbed per clock; K mod CHUNK SHALL be 0, checked at elaboration.
REQ-004 SHALL have parameter GEN_POLY, default 17'h1_6F63: generator polynomial, P+1 bits, MSB is x^P.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: global advance; when low, all state and outputs hold.
REQ-008 SHALL have port i_data, input, [0:K-1]: message; bit 0 is transmitted first.
REQ-009 SHALL have port i_valid, input, 1 bit: i_data is valid.
REQ-010 SHALL have port o_ready, output, 1 bit: encoder can accept a message.
REQ-011 SHALL have port o_code, output, [0:N-1]: N = K+P+X, where X is 1 with the macro in REQ-029 and 0 without it.
REQ-012 SHALL have port o_valid, output, 1 bit: o_code holds a finished codeword.
REQ-013 SHALL have port i_ready, input, 1 bit: downstream consumes o_code.

Function
REQ-014 SHALL produce a systematic code: o_code[0:K-1] = message, o_code[K:K+P-1] = remainder of m(x)*x^P mod GEN_POLY, MSB-first.
REQ-015 SHALL use a three-state FSM: IDLE, SHIFT, DONE.
REQ-016 IDLE: o_ready=1; when i_valid=1 and enable=1, SHALL latch i_data into a message register, clear the LFSR, clear the chunk counter, and go to SHIFT.
REQ-017 SHIFT: o_ready=0; each enabled cycle SHALL advance the LFSR by CHUNK bits, next chunk first (bits 0..CHUNK-1 first), and increment the chunk counter of width clog2(K/CHUNK).
REQ-018 SHALL leave SHIFT for DONE on the cycle the last chunk (counter = K/CHUNK-1) is absorbed; the counter SHALL NOT wrap past that chunk.
REQ-019 Latency: the acceptance edge at cycle T SHALL make o_valid=1 from cycle T+K/CHUNK, with enable held high.
REQ-020 DONE: o_valid=1 and o_code stable while i_ready=0; no new message accepted.
REQ-021 DONE with i_ready=1: o_ready SHALL be 1 in the same cycle; if i_valid=1 also, SHALL load the new message and go to SHIFT; otherwise SHALL go to IDLE (back-to-back throughput: one codeword per K/CHUNK+1 cycles).
REQ-022 When K = CHUNK, SHIFT SHALL last exactly one cycle.
REQ-023 o_code SHALL be driven from registers only, with no combinational path from i_data.
REQ-024 Outside DONE, o_valid SHALL be 0 and o_code SHALL retain its last value.

Reset
REQ-025 Reset at the clock edge SHALL force: state IDLE, o_valid=0, o_code=0, LFSR=0, counter=0, message register=0.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the codeword with no o_valid pulse; the abort takes priority over enable and i_valid.
REQ-027 o_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-028 Macro BCH_ENC_XPAR_EN SHALL be the only compile-time feature switch.
REQ-029 With BCH_ENC_XPAR_EN defined: X=1, and o_code[N-1] SHALL be the XOR of o_code[0:N-2] (even overall parity, DEC-TED); the parity bit SHALL be computed incrementally per chunk, with no added latency.
REQ-030 Without BCH_ENC_XPAR_EN: X=0, N=K+P, and no overall-parity logic is present.

Verification (defaults, BCH_ENC_XPAR_EN defined, N=145)
REQ-031 Reset, then i_data=0 with i_valid one cycle -> o_valid at T+4; o_code = all zeros.
REQ-032 i_data with only bit 127 set -> o_code[128:143]=16'h6F63, o_code[144]=1.
REQ-033 Two messages back-to-back with i_ready=1 -> the second is accepted in the DONE cycle of the first; o_valid pulses 5 cycles apart.
REQ-034 Downstream stall: i_ready=0 for 6 cycles in DONE -> o_code unchanged, o_ready=0, i_valid ignored; release -> completes normally.
REQ-035 Reset asserted at SHIFT cycle 2 -> no o_valid; o_code=0; next message encodes correctly.
REQ-036 enable=0 for 3 cycles mid-SHIFT -> o_valid delayed by exactly 3 cycles; codeword matches the software model.

Source files
------------

// File: rtl/bch_par_enc.sv
// rtl/bch_par_enc.sv - systematic BCH parity encoder absorbing CHUNK message bits per clock
// Optional overall even-parity bit (DEC-TED) enabled by defining BCH_ENC_XPAR_EN.
module bch_par_enc #(
   parameter int             K        = 128,
   parameter int             P        = 16,
   parameter int             CHUNK    = 32,
   parameter logic [P:0]     GEN_POLY = 17'h1_6F63
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [0:K-1]     i_data,
   input  logic             i_valid,
   output logic             o_ready,
`ifdef BCH_ENC_XPAR_EN
   output logic [0:K+P]     o_code,
`else
   output logic [0:K+P-1]   o_code,
`endif
   output logic             o_valid,
   input  logic             i_ready
);

`ifdef BCH_ENC_XPAR_EN
   localparam int N = K + P + 1;
`else
   localparam int N = K + P;
`endif
   localparam int NCHUNK = K / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   generate
      if (K % CHUNK != 0) begin : g_bad_chunk
         $error("bch_par_enc: K must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [0:K-1]    msg_q,   msg_d;
   logic [P-1:0]    lfsr_q,  lfsr_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [0:N-1]    code_q,  code_d;
`ifdef BCH_ENC_XPAR_EN
   logic            par_q,   par_d;
`endif

   logic [0:CHUNK-1] chunk;
   logic [P-1:0]     lfsr_step;
   logic             last_chunk;
   logic             accept;

   assign chunk      = msg_q[cnt_q*CHUNK +: CHUNK];
   assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

   // Galois division, one message bit per iteration, lowest chunk index first
   always_comb begin
      lfsr_step = lfsr_q;
      for (int i = 0; i < CHUNK; i++) begin
         lfsr_step = {lfsr_step[P-2:0], 1'b0}
                   ^ ({P{chunk[i] ^ lfsr_step[P-1]}} & GEN_POLY[P-1:0]);
      end
   end

   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
`ifdef BCH_ENC_XPAR_EN
      par_d   = par_q;
`endif
      accept  = 1'b0;
      o_ready = 1'b0;

      case (state_q)
         S_IDLE: begin
            o_ready = 1'b1;
            accept  = i_valid;
         end
         S_SHIFT: begin
            lfsr_d = lfsr_step;
`ifdef BCH_ENC_XPAR_EN
            par_d  = par_q ^ (^chunk);
`endif
            if (last_chunk) begin
               state_d = S_DONE;
`ifdef BCH_ENC_XPAR_EN
               code_d  = {msg_q, lfsr_step, par_q ^ (^chunk) ^ (^lfsr_step)};
`else
               code_d  = {msg_q, lfsr_step};
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            o_ready = i_ready;
            if (i_ready) begin
               accept  = i_valid;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         state_d = S_SHIFT;
         msg_d   = i_data;
         lfsr_d  = '0;
         cnt_d   = '0;
`ifdef BCH_ENC_XPAR_EN
         par_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         msg_q   <= '0;
         lfsr_q  <= '0;
         cnt_q   <= '0;
         code_q  <= '0;
`ifdef BCH_ENC_XPAR_EN
         par_q   <= 1'b0;
`endif
      end else if (enable) begin
         state_q <= state_d;
         msg_q   <= msg_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
`ifdef BCH_ENC_XPAR_EN
         par_q   <= par_d;
`endif
      end
   end

   assign o_code  = code_q;
   assign o_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_bch_par_enc.sv
// tb/tb_bch_par_enc.sv - directed-vector bench for bch_par_enc (K=128, P=16, CHUNK=32)
module tb_bch_par_enc;

   localparam int K = 128;
   localparam int P = 16;
`ifdef BCH_ENC_XPAR_EN
   localparam int N = K + P + 1;
`else
   localparam int N = K + P;
`endif

   logic          clk = 1'b0;
   logic          reset, enable, i_valid, i_ready, o_ready, o_valid;
   logic [0:K-1]  i_data;
   logic [0:N-1]  o_code;

   int nvec = 0;
   int nerr = 0;

   bch_par_enc dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .i_data  (i_data),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_code  (o_code),
      .o_valid (o_valid),
      .i_ready (i_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Long division of m(x)*x^P by g(x), written independently of the LFSR form
   function automatic logic [0:N-1] model(input logic [0:K-1] m);
      logic [0:K+P-1] d;
      logic [P:0]     g;
      logic [0:N-1]   r;
      g = 17'h1_6F63;
      d = {m, {P{1'b0}}};
      for (int i = 0; i < K; i++)
         if (d[i])
            for (int j = 0; j <= P; j++) d[i+j] = d[i+j] ^ g[P-j];
      r = '0;
      r[0:K-1]   = m;
      r[K:K+P-1] = d[K:K+P-1];
`ifdef BCH_ENC_XPAR_EN
      r[N-1] = ^{m, d[K:K+P-1]};
`endif
      return r;
   endfunction

   function automatic logic [0:N-1] hand(input logic [0:K-1] m, input logic [P-1:0] rem,
                                         input logic par);
      logic [0:N-1] r;
`ifdef BCH_ENC_XPAR_EN
      r = {m, rem, par};
`else
      r = {m, rem};
      if (par) r = r;
`endif
      return r;
   endfunction

   task automatic wait_valid(output int n);
      n = 0;
      while (!o_valid && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic accept(input logic [0:K-1] m);
      i_data  = m;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic run_one(input string tag, input logic [0:K-1] m, input logic [0:N-1] exp);
      int n;
      accept(m);
      chk({tag, "_busy"}, {255'd0, o_ready}, 256'd0);
      wait_valid(n);
      chk({tag, "_lat"}, n, 4);
      chk({tag, "_code"}, o_code, exp);
      tick();
      chk({tag, "_idle"}, {255'd0, o_valid}, 256'd0);
   endtask

   initial begin
      int n, n2;
      logic [0:K-1] ma, mb;
      logic         bad;

      reset = 1'b1; enable = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_data = '0;
      tick(); tick();
      chk("rst_valid", {255'd0, o_valid}, 256'd0);
      chk("rst_code",  o_code, 256'd0);
      reset = 1'b0;
      tick();
      chk("rst_ready", {255'd0, o_ready}, 256'd1);

      run_one("zero",   '0,         '0);
      run_one("bit127", 128'h1,     hand(128'h1, 16'h6F63, 1'b1));
      run_one("bit126", 128'h2,     hand(128'h2, 16'hDEC6, 1'b1));
      run_one("bit0",   {1'b1, 127'd0}, model({1'b1, 127'd0}));
      run_one("rnd1",   128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE,
              model(128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE));
      run_one("ones",   '1,         model('1));

      // back-to-back: second message accepted in the DONE cycle of the first
      ma = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
      mb = 128'hA5A5_5A5A_FFFF_0000_1357_9BDF_2468_ACE0;
      accept(ma);
      wait_valid(n);
      chk("b2b_lat", n, 4);
      i_data  = mb;
      i_valid = 1'b1;
      #1;
      chk("b2b_ready", {255'd0, o_ready}, 256'd1);
      chk("b2b_codeA", o_code, model(ma));
      tick();
      i_valid = 1'b0;
      chk("b2b_gap", {255'd0, o_valid}, 256'd0);
      wait_valid(n2);
      chk("b2b_period", n2 + 1, 5);
      chk("b2b_codeB", o_code, model(mb));
      tick();

      // downstream stall in DONE
      i_ready = 1'b0;
      accept(ma);
      wait_valid(n);
      i_data  = mb;
      i_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk("stall_ready", {255'd0, o_ready}, 256'd0);
         chk("stall_valid", {255'd0, o_valid}, 256'd1);
         chk("stall_code",  o_code, model(ma));
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      tick();
      chk("stall_rel_valid", {255'd0, o_valid}, 256'd0);
      chk("stall_rel_ready", {255'd0, o_ready}, 256'd1);

      // reset in SHIFT aborts the codeword
      accept(mb);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_code",  o_code, 256'd0);
      chk("abort_ready", {255'd0, o_ready}, 256'd1);
      bad = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         bad = bad | o_valid;
      end
      chk("abort_novalid", {255'd0, bad}, 256'd0);
      run_one("post_abort", ma, model(ma));

      // enable low for 3 cycles mid-SHIFT
      accept(mb);
      tick();
      enable = 1'b0;
      tick(); tick(); tick();
      chk("stall_en_valid", {255'd0, o_valid}, 256'd0);
      enable = 1'b1;
      wait_valid(n);
      chk("en_lat", n + 4, 7);
      chk("en_code", o_code, model(mb));
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
